alu_result_stage: RTL

- Registered output stage directly downstream of the combinational subtractor/adder.
- Captures the SIZE+1-bit sign-extended result and the overflow bit, and optionally saturates the result to SIZE bits.
- Derives the V/S/N/Z status flags and keeps a saturating overflow event counter.
- Provides a valid/ready handshake with a 2-entry skid buffer, so the ALU datapath can be stalled by the consumer without losing results.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_skid_buffer.sv | 51 +++++
 rtl/alu_result_stage.sv | 76 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU result path: flag positions, the
// output payload struct, and the saturation bounds.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 8;
  localparam int unsigned FLAG_W     = 4;
  localparam int unsigned SAT_W      = 64;

  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] data;
    logic [FLAG_W-1:0]     flags;
  } alu_out_t;

  // Largest positive two's-complement value of a size-bit word.
  function automatic logic [SAT_W-1:0] sat_max(input int unsigned size);
    return (SAT_W'(1) << (size - 1)) - SAT_W'(1);
  endfunction

  // Most negative two's-complement value of a size-bit word.
  function automatic logic [SAT_W-1:0] sat_min(input int unsigned size);
    return SAT_W'(1) << (size - 1);
  endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry valid/ready skid buffer; out_data is the main entry register,
// a second register absorbs one extra beat while the consumer stalls.
module alu_skid_buffer #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         main_free;

  assign accept    = in_valid && in_ready;
  assign main_free = !out_valid || out_ready;

  // in_ready tracks !skid_valid as its own register so it never depends on out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
    end else if (main_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      in_ready   <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: optional saturation, V/S/N/Z flags, a
// saturating overflow event counter, and a skid-buffered handshake.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned SIZE  = ALU_DATA_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE:0]    in_result,
  input  logic             in_overflow,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_data,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clear
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SIZE-1:0] data_c;
  logic [3:0]      flags_c;
  alu_out_t        in_pl;
  alu_out_t        out_pl;
  logic            accept;

  assign accept = in_valid && in_ready;

  // Result shaping happens before storage so both skid entries hold final values.
  always_comb begin
    data_c = in_result[SIZE-1:0];
    if (in_overflow && sat_en) begin
      data_c = in_result[SIZE] ? SIZE'(sat_min(SIZE)) : SIZE'(sat_max(SIZE));
    end
    flags_c         = '0;
    flags_c[FLAG_V] = in_overflow;
    flags_c[FLAG_S] = in_result[SIZE];
    flags_c[FLAG_N] = data_c[SIZE-1];
    flags_c[FLAG_Z] = (data_c == '0);
    in_pl.data      = ALU_DATA_W'(data_c);
    in_pl.flags     = flags_c;
  end

  alu_skid_buffer #(
    .W($bits(alu_out_t))
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign out_data  = SIZE'(out_pl.data);
  assign out_flags = out_pl.flags;

  // Clear wins over increment but still counts an overflow accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_count <= (accept && in_overflow) ? CNT_W'(1) : '0;
    end else if (accept && in_overflow && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule
